mmio_console: RTL and testbench

MMIO_CONSOLE -- requirements
Module: mmio_console

---
 rtl/mmio_console.sv | 106 ++++++++++
 tb/tb_mmio_console.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mmio_console.sv
// rtl/mmio_console.sv - memory-mapped console: character FIFO, drop counter and exit handshake
module mmio_console #(
    parameter int          DEPTH     = 16,
    parameter logic [31:0] PUTC_ADDR = 32'h9000001c,
    parameter logic [31:0] EXIT_ADDR = 32'h9000002c
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wvalid,
    input  logic [31:0]                waddr,
    input  logic [31:0]                wdata,
    input  logic [3:0]                 wstrb,
    output logic                       hit,
    output logic                       tx_valid,
    input  logic                       tx_ready,
    output logic [7:0]                 tx_data,
    output logic [$clog2(DEPTH):0]     level,
    output logic [7:0]                 dropped,
    output logic                       exit_done,
    output logic [31:0]                exit_code
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL = LW'(DEPTH);

    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

    state_t         state;
    logic           drain_first;
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [7:0]     mem [DEPTH];

    logic exit_wr;
    logic putc_wr;
    logic pop;
    logic push_ok;
    logic drop;

    assign hit     = wvalid && ((waddr == PUTC_ADDR) || (waddr == EXIT_ADDR));
    assign exit_wr = wvalid && (waddr == EXIT_ADDR);
    // EXIT wins if both decodes ever fire on the same write
    assign putc_wr = wvalid && (waddr == PUTC_ADDR) && wstrb[0] && !exit_wr;

    assign tx_valid  = (level != '0);
    assign tx_data   = mem[rd_ptr];
    assign exit_done = (state == DONE);

    assign pop     = tx_valid && tx_ready;
    assign push_ok = putc_wr && (state == RUN) && ((level != FULL) || pop);
    assign drop    = putc_wr && !push_ok;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            dropped     <= 8'd0;
            exit_code   <= 32'd0;
            state       <= RUN;
            drain_first <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (drop && (dropped != 8'hff)) begin
                dropped <= dropped + 8'd1;
            end

            // drain_first holds off DONE for one cycle so an empty-FIFO exit takes two cycles
            drain_first <= 1'b0;
            case (state)
                RUN: begin
                    if (exit_wr) begin
                        exit_code   <= wdata;
                        state       <= DRAIN;
                        drain_first <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (!drain_first && (level == '0)) begin
                        state <= DONE;
                    end
                end
                DONE:    state <= DONE;
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_console.sv
// tb/tb_mmio_console.sv - directed self-checking bench for mmio_console
module tb_mmio_console;

    localparam logic [31:0] PUTC = 32'h9000001c;
    localparam logic [31:0] EXIT = 32'h9000002c;

    logic        clk = 1'b0;
    logic        reset;
    logic        wvalid;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        hit;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  tx_data;
    logic [4:0]  level;
    logic [7:0]  dropped;
    logic        exit_done;
    logic [31:0] exit_code;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mmio_console dut (
        .clk       (clk),
        .reset     (reset),
        .wvalid    (wvalid),
        .waddr     (waddr),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .hit       (hit),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_data   (tx_data),
        .level     (level),
        .dropped   (dropped),
        .exit_done (exit_done),
        .exit_code (exit_code)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        wvalid = 1'b1;
        waddr  = a;
        wdata  = d;
        wstrb  = s;
    endtask

    task automatic write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        set_write(a, d, s);
        tick();
        wvalid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        wvalid   = 1'b0;
        waddr    = 32'd0;
        wdata    = 32'd0;
        wstrb    = 4'd0;
        tx_ready = 1'b0;
        tick();
        set_write(PUTC, 32'h11, 4'hf);
        #1 check("hit_in_reset", hit, 1'b1);
        tick();
        wvalid = 1'b0;
        reset  = 1'b0;
        check("rst_level", level, 0);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_dropped", dropped, 0);
        check("rst_exit_done", exit_done, 0);
        check("rst_exit_code", exit_code, 0);

        // "Hi" with a ready sink
        tx_ready = 1'b1;
        write(PUTC, 32'h48, 4'h1);
        check("hi_h_data", tx_data, 8'h48);
        check("hi_h_level", level, 1);
        write(PUTC, 32'hffff_ff69, 4'h1);
        check("hi_i_data", tx_data, 8'h69);
        check("hi_i_level", level, 1);
        tick();
        check("hi_level_end", level, 0);
        check("hi_dropped", dropped, 0);

        // overfill with a stalled sink
        tx_ready = 1'b0;
        for (int i = 0; i < 18; i++) write(PUTC, 32'h41 + i, 4'h1);
        check("full_level", level, 16);
        check("full_dropped", dropped, 2);
        check("full_head", tx_data, 8'h41);

        // push while full and popping
        tx_ready = 1'b1;
        write(PUTC, 32'h7a, 4'h1);
        check("fullpp_level", level, 16);
        check("fullpp_dropped", dropped, 2);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("order_%0d", i), tx_data, (i < 15) ? (8'h42 + i) : 8'h7a);
            tick();
        end
        check("order_level_end", level, 0);
        check("order_tx_valid_end", tx_valid, 0);

        // lane-0 gating and foreign addresses
        do_reset();
        check("rst2_dropped", dropped, 0);
        set_write(PUTC, 32'h55, 4'b0010);
        #1 check("lane_hit", hit, 1);
        tick();
        wvalid = 1'b0;
        check("lane_level", level, 0);
        check("lane_dropped", dropped, 0);
        set_write(32'h9000_0020, 32'h66, 4'hf);
        #1 check("other_hit", hit, 0);
        tick();
        wvalid = 1'b0;
        check("other_level", level, 0);
        check("other_exit_done", exit_done, 0);
        check("other_exit_code", exit_code, 0);

        // exit with three bytes pending
        tx_ready = 1'b0;
        write(PUTC, 32'h31, 4'h1);
        write(PUTC, 32'h32, 4'h1);
        write(PUTC, 32'h33, 4'h1);
        write(EXIT, 32'h2a, 4'h1);
        check("drain_exit_code", exit_code, 32'h2a);
        check("drain_exit_done0", exit_done, 0);
        write(PUTC, 32'h34, 4'h1);
        check("drain_putc_dropped", dropped, 1);
        check("drain_putc_level", level, 3);
        tick();
        check("drain_exit_done1", exit_done, 0);
        tx_ready = 1'b1;
        check("drain_pop0", tx_data, 8'h31);
        tick();
        check("drain_pop1", tx_data, 8'h32);
        tick();
        check("drain_pop2", tx_data, 8'h33);
        tick();
        check("drain_level0", level, 0);
        check("drain_exit_done2", exit_done, 0);
        tick();
        check("done_exit_done", exit_done, 1);
        write(EXIT, 32'h5, 4'hf);
        check("done_exit_code", exit_code, 32'h2a);
        check("done_hold", exit_done, 1);

        // exit with empty FIFO: DONE two edges after the write
        do_reset();
        write(EXIT, 32'h77, 4'h0);
        check("empty_exit_e0", exit_done, 0);
        tick();
        check("empty_exit_e1", exit_done, 0);
        tick();
        check("empty_exit_e2", exit_done, 1);
        check("empty_exit_code", exit_code, 32'h77);

        // reset mid-drain with five bytes queued
        do_reset();
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) write(PUTC, 32'h61 + i, 4'h1);
        write(EXIT, 32'h9, 4'hf);
        write(PUTC, 32'h70, 4'h1);
        check("mid_level", level, 5);
        check("mid_dropped", dropped, 1);
        do_reset();
        check("mid_rst_level", level, 0);
        check("mid_rst_tx_valid", tx_valid, 0);
        check("mid_rst_dropped", dropped, 0);
        check("mid_rst_exit_done", exit_done, 0);
        write(PUTC, 32'h7e, 4'h1);
        check("mid_run_level", level, 1);
        check("mid_run_data", tx_data, 8'h7e);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
